// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with operand forwarding, load-use bubbles, flush/hold (EX_FORWARD_EN enables EX-side forwarding)
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic        id_alusrc_a,
  input  logic        id_alusrc_b,
  input  logic [5:0]  id_alufun,
  input  logic [4:0]  id_wr_addr,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        ex_mem_regwrite,
  input  logic [4:0]  ex_mem_wr_addr,
  input  logic [31:0] ex_mem_result,
  input  logic        mem_wb_regwrite,
  input  logic [4:0]  mem_wb_wr_addr,
  input  logic [31:0] mem_wb_data,
  input  logic        flush,
  input  logic        hold,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [5:0]  ex_alufun,
  output logic [4:0]  ex_wr_addr,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic [31:0] ex_store_data
);
  typedef struct packed {
    logic        v;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        srca;
    logic        srcb;
    logic [5:0]  fun;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
  } stage_t;
  stage_t q, cap;
  logic [31:0] fwd_rs, fwd_rt;
  logic lu, haz;
  function automatic logic hit(input logic we, input logic [4:0] wa, input logic [4:0] ra);
    return we && wa != 5'd0 && wa == ra;
  endfunction
  assign lu = id_valid && q.mr && (hit(q.v, q.wr, id_rs_addr) || hit(q.v, q.wr, id_rt_addr));
`ifdef EX_FORWARD_EN
  assign fwd_rs = hit(ex_mem_regwrite, ex_mem_wr_addr, q.rs_a) ? ex_mem_result :
                  hit(mem_wb_regwrite, mem_wb_wr_addr, q.rs_a) ? mem_wb_data : q.rs_d;
  assign fwd_rt = hit(ex_mem_regwrite, ex_mem_wr_addr, q.rt_a) ? ex_mem_result :
                  hit(mem_wb_regwrite, mem_wb_wr_addr, q.rt_a) ? mem_wb_data : q.rt_d;
  assign haz = lu;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_mem_result, q.rs_a, q.rt_a};
  assign fwd_rs = q.rs_d;
  assign fwd_rt = q.rt_d;
  assign haz = lu || (id_valid && (hit(q.v && q.rw, q.wr, id_rs_addr) || hit(q.v && q.rw, q.wr, id_rt_addr) ||
               hit(ex_mem_regwrite, ex_mem_wr_addr, id_rs_addr) || hit(ex_mem_regwrite, ex_mem_wr_addr, id_rt_addr)));
`endif
  always_comb begin
    cap = '0;
    if (id_valid) begin
      cap.v     = 1'b1;
      cap.rs_a  = id_rs_addr;
      cap.rt_a  = id_rt_addr;
      cap.rs_d  = hit(mem_wb_regwrite, mem_wb_wr_addr, id_rs_addr) ? mem_wb_data : id_rs_data;
      cap.rt_d  = hit(mem_wb_regwrite, mem_wb_wr_addr, id_rt_addr) ? mem_wb_data : id_rt_data;
      cap.imm   = id_imm;
      cap.shamt = id_shamt;
      cap.srca  = id_alusrc_a;
      cap.srcb  = id_alusrc_b;
      cap.fun   = id_alufun;
      cap.wr    = id_wr_addr;
      cap.rw    = id_regwrite;
      cap.mr    = id_memread;
      cap.mw    = id_memwrite;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset || flush || (!hold && haz))
      q <= '0;
    else if (!hold)
      q <= cap;
  end
  assign id_stall      = reset && (hold || haz);
  assign ex_valid      = q.v;
  assign ex_A          = q.srca ? {27'b0, q.shamt} : fwd_rs;
  assign ex_B          = q.srcb ? q.imm : fwd_rt;
  assign ex_alufun     = q.fun;
  assign ex_wr_addr    = q.wr;
  assign ex_regwrite   = q.rw;
  assign ex_memread    = q.mr;
  assign ex_memwrite   = q.mw;
  assign ex_store_data = fwd_rt;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: table-driven scoreboard bench for ex_operand_stage
module tb_ex_operand_stage;
`ifdef EX_FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif
  localparam logic I = 1'b1, O = 1'b0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [4:0] Z5 = 5'd0;
  localparam logic [5:0] Z6 = 6'h0;
  typedef struct packed {
    logic        v, rw, mr, mw, st;
    logic [5:0]  fun;
    logic [4:0]  wr;
    logic [31:0] a, b, sd;
  } exp_t;
  typedef struct {
    logic rst, idv;
    logic [4:0] rs, rt;
    logic [31:0] rsd, rtd, imm;
    logic [4:0] sh;
    logic sa, sb;
    logic [5:0] fun;
    logic [4:0] wr;
    logic rw, mr, mw;
    logic emw;
    logic [4:0] ema;
    logic [31:0] emd;
    logic mww;
    logic [4:0] mwa;
    logic [31:0] mwd;
    logic fl, hd;
    exp_t e;
  } vec_t;
  logic clk, reset, id_valid, id_alusrc_a, id_alusrc_b, id_regwrite, id_memread, id_memwrite;
  logic [4:0] id_rs_addr, id_rt_addr, id_shamt, id_wr_addr, ex_mem_wr_addr, mem_wb_wr_addr, ex_wr_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm, ex_mem_result, mem_wb_data, ex_A, ex_B, ex_store_data;
  logic [5:0] id_alufun, ex_alufun;
  logic ex_mem_regwrite, mem_wb_regwrite, flush, hold, id_stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  int tests = 0, fails = 0, step_no = 0;
  exp_t sb_q[$];
  vec_t tv[20];
  vec_t h;
  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b), .id_alufun(id_alufun), .id_wr_addr(id_wr_addr),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_wr_addr(ex_mem_wr_addr), .ex_mem_result(ex_mem_result),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_wr_addr(mem_wb_wr_addr), .mem_wb_data(mem_wb_data),
    .flush(flush), .hold(hold), .id_stall(id_stall), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
    .ex_alufun(ex_alufun), .ex_wr_addr(ex_wr_addr), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic drive(input vec_t x);
    reset = x.rst; id_valid = x.idv; id_rs_addr = x.rs; id_rt_addr = x.rt;
    id_rs_data = x.rsd; id_rt_data = x.rtd; id_imm = x.imm; id_shamt = x.sh;
    id_alusrc_a = x.sa; id_alusrc_b = x.sb; id_alufun = x.fun; id_wr_addr = x.wr;
    id_regwrite = x.rw; id_memread = x.mr; id_memwrite = x.mw;
    ex_mem_regwrite = x.emw; ex_mem_wr_addr = x.ema; ex_mem_result = x.emd;
    mem_wb_regwrite = x.mww; mem_wb_wr_addr = x.mwa; mem_wb_data = x.mwd;
    flush = x.fl; hold = x.hd;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL step %0d %s: got %h expected %h", step_no, n, a, e);
    end
  endtask
  task automatic step(input vec_t x);
    exp_t e;
    @(negedge clk);
    drive(x);
    sb_q.push_back(x.e);
    #1;
    e = sb_q.pop_front();
    chk("ex_valid", 32'(ex_valid), 32'(e.v));
    chk("ex_regwrite", 32'(ex_regwrite), 32'(e.rw));
    chk("ex_memread", 32'(ex_memread), 32'(e.mr));
    chk("ex_memwrite", 32'(ex_memwrite), 32'(e.mw));
    chk("id_stall", 32'(id_stall), 32'(e.st));
    chk("ex_alufun", 32'(ex_alufun), 32'(e.fun));
    chk("ex_wr_addr", 32'(ex_wr_addr), 32'(e.wr));
    chk("ex_A", ex_A, e.a);
    chk("ex_B", ex_B, e.b);
    chk("ex_store_data", ex_store_data, e.sd);
    step_no++;
  endtask
  initial begin
    tv[0]  = '{O,I,5'd1,5'd2,32'h11,32'h22,Z32,Z5,O,O,6'h20,5'd3,I,O,O, O,Z5,Z32, O,Z5,Z32, O,I, '{O,O,O,O,O,Z6,Z5,Z32,Z32,Z32}};
    tv[1]  = '{I,I,Z5,5'd10,Z32,32'hF,Z32,5'd4,I,O,6'h20,5'd11,I,O,O, O,Z5,Z32, O,Z5,Z32, O,O, '{O,O,O,O,O,Z6,Z5,Z32,Z32,Z32}};
    tv[2]  = '{I,O,Z5,Z5,Z32,Z32,Z32,Z5,O,O,Z6,Z5,O,O,O, O,Z5,Z32, O,Z5,Z32, O,O, '{I,I,O,O,O,6'h20,5'd11,32'h4,32'hF,32'hF}};
    tv[3]  = '{I,I,5'd8,Z5,32'hDEADBEEF,Z32,Z32,Z5,O,O,6'h21,5'd12,I,O,O, O,Z5,Z32, O,Z5,Z32, O,O, '{O,O,O,O,O,Z6,Z5,Z32,Z32,Z32}};
    tv[4]  = '{I,O,Z5,Z5,Z32,Z32,Z32,Z5,O,O,Z6,Z5,O,O,O, I,5'd8,32'h1234, I,5'd8,32'h55555555, O,I,
               '{I,I,O,O,I,6'h21,5'd12,FWD ? 32'h1234 : 32'hDEADBEEF,Z32,Z32}};
    tv[5]  = '{I,O,Z5,Z5,Z32,Z32,Z32,Z5,O,O,Z6,Z5,O,O,O, O,5'd8,32'h1234, I,5'd8,32'h55555555, O,I,
               '{I,I,O,O,I,6'h21,5'd12,FWD ? 32'h55555555 : 32'hDEADBEEF,Z32,Z32}};
    tv[6]  = '{I,I,Z5,Z5,Z32,Z32,32'h10,Z5,O,I,6'h23,5'd9,I,I,O, O,Z5,Z32, O,Z5,Z32, O,O, '{I,I,O,O,O,6'h21,5'd12,32'hDEADBEEF,Z32,Z32}};
    tv[7]  = '{I,I,5'd9,Z5,32'h77,Z32,Z32,Z5,O,O,6'h20,5'd13,I,O,O, I,Z5,32'hFFFFFFFF, O,Z5,Z32, O,O, '{I,I,I,O,I,6'h23,5'd9,Z32,32'h10,Z32}};
    tv[8]  = '{I,I,5'd9,Z5,32'h77,Z32,Z32,Z5,O,O,6'h20,5'd13,I,O,O, O,Z5,Z32, O,Z5,Z32, O,O, '{O,O,O,O,O,Z6,Z5,Z32,Z32,Z32}};
    tv[9]  = '{I,I,5'd1,5'd2,32'h5,32'h6,Z32,Z5,O,O,6'h20,5'd16,I,O,O, O,Z5,Z32, O,Z5,Z32, I,I, '{I,I,O,O,I,6'h20,5'd13,32'h77,Z32,Z32}};
    tv[10] = '{I,I,5'd5,5'd6,32'h1,32'h2,Z32,Z5,O,O,6'h2B,5'd14,I,O,I, O,Z5,Z32, I,5'd6,32'hCAFEF00D, O,O, '{O,O,O,O,O,Z6,Z5,Z32,Z32,Z32}};
    tv[11] = '{I,O,Z5,Z5,Z32,Z32,Z32,Z5,O,O,Z6,Z5,O,O,O, O,Z5,Z32, O,Z5,Z32, O,O, '{I,I,O,I,O,6'h2B,5'd14,32'h1,32'hCAFEF00D,32'hCAFEF00D}};
    tv[12] = '{I,I,Z5,Z5,Z32,Z32,Z32,Z5,O,O,6'h23,5'd9,I,I,O, O,Z5,Z32, O,Z5,Z32, O,O, '{O,O,O,O,O,Z6,Z5,Z32,Z32,Z32}};
    tv[13] = '{I,I,5'd9,Z5,32'h77,Z32,Z32,Z5,O,O,6'h20,5'd13,I,O,O, O,Z5,Z32, O,Z5,Z32, I,O, '{I,I,I,O,I,6'h23,5'd9,Z32,Z32,Z32}};
    tv[14] = '{I,I,Z5,Z5,Z32,Z32,Z32,Z5,O,O,6'h23,5'd9,I,I,O, O,Z5,Z32, O,Z5,Z32, O,O, '{O,O,O,O,O,Z6,Z5,Z32,Z32,Z32}};
    tv[15] = '{O,I,5'd9,Z5,32'h77,Z32,Z32,Z5,O,O,6'h20,5'd13,I,O,O, O,Z5,Z32, O,Z5,Z32, O,O, '{I,I,I,O,O,6'h23,5'd9,Z32,Z32,Z32}};
    tv[16] = '{I,I,5'd9,Z5,32'h77,Z32,Z32,Z5,O,O,6'h20,5'd13,I,O,O, O,Z5,Z32, O,Z5,Z32, O,O, '{O,O,O,O,O,Z6,Z5,Z32,Z32,Z32}};
    tv[17] = '{I,I,5'd13,Z5,32'h99,Z32,Z32,Z5,O,O,6'h22,5'd15,I,O,O, O,Z5,Z32, O,Z5,Z32, O,O, '{I,I,O,O,~FWD,6'h20,5'd13,32'h77,Z32,Z32}};
    tv[18] = '{I,O,Z5,Z5,Z32,Z32,Z32,Z5,O,O,Z6,Z5,O,O,O, O,Z5,Z32, O,Z5,Z32, O,O,
               '{FWD,FWD,O,O,O,FWD ? 6'h22 : Z6,FWD ? 5'd15 : Z5,FWD ? 32'h99 : Z32,Z32,Z32}};
    tv[19] = '{I,O,Z5,Z5,Z32,Z32,Z32,Z5,O,O,Z6,Z5,O,O,O, O,Z5,Z32, O,Z5,Z32, O,O, '{O,O,O,O,O,Z6,Z5,Z32,Z32,Z32}};
    drive(tv[0]);
    @(posedge clk);
    for (int i = 0; i < 20; i++) step(tv[i]);
    h = tv[12];
    step(h);
    h = tv[13];
    h.fl = O;
    h.hd = I;
    step(h);
    step(h);
    h.hd = O;
    step(h);
    h.e = '{O,O,O,O,O,Z6,Z5,Z32,Z32,Z32};
    step(h);
    h = tv[19];
    h.e = '{I,I,O,O,O,6'h20,5'd13,32'h77,Z32,Z32};
    step(h);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
